// File: rtl/bist_pkg.sv
// Shared types and constants for the link BIST sequencer and its tx/rx pairs.
package bist_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LINK_RST = 3'd1,
        RUN      = 3'd2,
        RECORD   = 3'd3,
        DONE     = 3'd4
    } bist_seq_state_t;

    localparam logic [15:0] BIST_LFSR_SEED     = 16'hACE1;
    localparam int          BIST_TEST_CASES    = 256;
    localparam int          BIST_DEF_LINKS     = 5;
    localparam int          BIST_DEF_RST_CYC   = 2;
    localparam int          BIST_DEF_TIMEOUT   = 2048;
    localparam int          BIST_DEF_RETRIES   = 1;

    // Link index width; a single link still gets a 1-bit select.
    function automatic int link_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/bist_sequencer_if.sv
// Control/status bundle between the BIST sequencer and the link BIST pairs.
interface bist_sequencer_if #(
    parameter int NUM_LINKS = 5,
    parameter int LW        = bist_pkg::link_w(NUM_LINKS)
);
    logic                 start;
    logic [NUM_LINKS-1:0] link_ready;
    logic [NUM_LINKS-1:0] link_failed;
    logic [NUM_LINKS-1:0] bist_reset;
    logic                 busy;
    logic                 done;
    logic [LW-1:0]        link_sel;
    logic [NUM_LINKS-1:0] pass_mask;
    logic [NUM_LINKS-1:0] fail_mask;

    modport master (
        output start, link_ready, link_failed,
        input  bist_reset, busy, done, link_sel, pass_mask, fail_mask
    );
    modport slave (
        input  start, link_ready, link_failed,
        output bist_reset, busy, done, link_sel, pass_mask, fail_mask
    );
endinterface

// File: rtl/bist_timer.sv
// Loadable saturating down-counter; expire is high while the count sits at zero.
module bist_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 r_count <= '0;
        else if (i_clear)          r_count <= '0;
        else if (i_load)           r_count <= i_load_val;
        else if (r_count != '0)    r_count <= r_count - 1'b1;
    end

    assign o_expire = (r_count == '0);
endmodule

// File: rtl/bist_sequencer.sv
// Runs each link's BIST pair in turn with timeout and retry, and publishes
// pass/fail masks; only passing links are released from BIST reset.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int NUM_LINKS      = BIST_DEF_LINKS,
    parameter int RESET_CYCLES   = BIST_DEF_RST_CYC,
    parameter int TIMEOUT_CYCLES = BIST_DEF_TIMEOUT,
    parameter int MAX_RETRIES    = BIST_DEF_RETRIES
) (
    input logic              clk,
    input logic              reset,
    bist_sequencer_if.slave  bus
);
    localparam int LW    = link_w(NUM_LINKS);
    localparam int TMAX  = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int RW    = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    bist_seq_state_t      r_state, w_state_nxt;
    logic [LW-1:0]        r_sel, w_sel_nxt;
    logic [RW-1:0]        r_retry, w_retry_nxt;
    logic [NUM_LINKS-1:0] r_pass, w_pass_nxt;
    logic [NUM_LINKS-1:0] r_fail, w_fail_nxt;
    logic [NUM_LINKS-1:0] r_bist_rst, w_bist_rst_nxt;
    logic                 r_result, w_result_nxt;
    logic                 w_final;
    logic                 w_tmr_clear, w_tmr_load, w_tmr_expire;
    logic [TW-1:0]        w_tmr_val;
    logic                 w_ready, w_failed;
    logic [NUM_LINKS-1:0] w_sel_oh;

    // One timer serves both the reset hold and the run timeout.
    bist_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_tmr_clear),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_tmr_expire)
    );

    assign w_ready  = bus.link_ready[r_sel];
    assign w_failed = bus.link_failed[r_sel];

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_retry_nxt  = r_retry;
        w_pass_nxt   = r_pass;
        w_fail_nxt   = r_fail;
        w_result_nxt = r_result;
        w_final      = 1'b0;
        w_tmr_clear  = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = LINK_RST;
                    w_sel_nxt   = '0;
                    w_retry_nxt = '0;
                    w_pass_nxt  = '0;
                    w_fail_nxt  = '0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(RESET_CYCLES - 1);
                end
            end
            LINK_RST: begin
                if (w_tmr_expire) begin
                    w_state_nxt = RUN;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(TIMEOUT_CYCLES - 1);
                end
            end
            RUN: begin
                // Readiness is checked first so it wins over a coincident timeout.
                if (w_ready) begin
                    w_state_nxt  = RECORD;
                    w_result_nxt = ~w_failed;
                end else if (w_tmr_expire) begin
                    w_state_nxt  = RECORD;
                    w_result_nxt = 1'b0;
                end
            end
            RECORD: begin
                w_final = 1'b1;
                if (r_result) begin
                    w_pass_nxt[r_sel] = 1'b1;
                end else if (r_retry < RW'(MAX_RETRIES)) begin
                    w_final     = 1'b0;
                    w_retry_nxt = r_retry + 1'b1;
                    w_state_nxt = LINK_RST;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(RESET_CYCLES - 1);
                end else begin
                    w_fail_nxt[r_sel] = 1'b1;
                end
                if (w_final) begin
                    if (r_sel == LW'(NUM_LINKS - 1)) begin
                        w_state_nxt = DONE;
                        w_tmr_clear = 1'b1;
                    end else begin
                        w_sel_nxt   = r_sel + 1'b1;
                        w_retry_nxt = '0;
                        w_state_nxt = LINK_RST;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(RESET_CYCLES - 1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A link is out of reset only while under test or once it has passed.
    assign w_sel_oh       = NUM_LINKS'(1) << w_sel_nxt;
    assign w_bist_rst_nxt = ~(w_pass_nxt |
                              (((w_state_nxt == RUN) || (w_state_nxt == RECORD)) ? w_sel_oh : '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_retry    <= '0;
            r_pass     <= '0;
            r_fail     <= '0;
            r_result   <= 1'b0;
            r_bist_rst <= '1;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_retry    <= w_retry_nxt;
            r_pass     <= w_pass_nxt;
            r_fail     <= w_fail_nxt;
            r_result   <= w_result_nxt;
            r_bist_rst <= w_bist_rst_nxt;
        end
    end

    assign bus.busy       = (r_state == LINK_RST) || (r_state == RUN) || (r_state == RECORD);
    assign bus.done       = (r_state == DONE);
    assign bus.link_sel   = r_sel;
    assign bus.pass_mask  = r_pass;
    assign bus.fail_mask  = r_fail;
    assign bus.bist_reset = r_bist_rst;
endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench: a per-link receiver model answers each attempt from a delay/fail table.
module tb_bist_sequencer;
    import bist_pkg::*;

    localparam int NL = 4;
    localparam int LW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bist_sequencer_if #(.NUM_LINKS(NL), .LW(LW)) bus ();

    bist_sequencer #(
        .NUM_LINKS(NL), .RESET_CYCLES(2), .TIMEOUT_CYCLES(64), .MAX_RETRIES(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Per-link, per-attempt response table: ready after dly RUN cycles, with fl as the result.
    int   dly [NL][2];
    logic fl  [NL][2];
    int   cnt [NL];
    int   cur [NL];
    int   nfall [NL];
    logic prev [NL];
    int   lo_cnt [NL];
    int   hi_cnt [NL];
    bit   noise = 1'b0;

    initial begin
        logic r;
        bus.link_ready  = '0;
        bus.link_failed = '0;
        for (int i = 0; i < NL; i++) begin
            cnt[i] = 0; cur[i] = 0; nfall[i] = 0; prev[i] = 1'b1;
            lo_cnt[i] = 0; hi_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                if (!bus.bist_reset[i] && prev[i]) begin
                    cur[i] = (nfall[i] > 1) ? 1 : nfall[i];
                    nfall[i]++;
                    cnt[i] = 0;
                end
                cnt[i]  = bus.bist_reset[i] ? 0 : cnt[i] + 1;
                prev[i] = bus.bist_reset[i];
                if (bus.busy && int'(bus.link_sel) == i) begin
                    if (bus.bist_reset[i]) hi_cnt[i]++;
                    else                   lo_cnt[i]++;
                end
                r = !bus.bist_reset[i] && (cnt[i] >= dly[i][cur[i]]);
                if (noise && int'(bus.link_sel) != i) begin
                    bus.link_ready[i]  = 1'($urandom);
                    bus.link_failed[i] = 1'($urandom);
                end else begin
                    bus.link_ready[i]  = r;
                    bus.link_failed[i] = r & fl[i][cur[i]];
                end
            end
        end
    end

    task automatic cfg_all(input int d, input logic f);
        for (int i = 0; i < NL; i++)
            for (int a = 0; a < 2; a++) begin
                dly[i][a] = d;
                fl[i][a]  = f;
            end
    endtask

    task automatic go();
        @(posedge clk); #1;
        for (int i = 0; i < NL; i++) begin
            cnt[i] = 0; cur[i] = 0; nfall[i] = 0; prev[i] = bus.bist_reset[i];
            lo_cnt[i] = 0; hi_cnt[i] = 0;
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int   k;
        logic pb;
        pb = 1'b0;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.done) break;
            pb = bus.busy;
        end
        chk({tag, " done reached"}, 32'(k < 2000), 32'd1);
        chk({tag, " busy before done"}, 32'(pb), 32'd1);
        chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        chk({tag, " masks disjoint"}, 32'(bus.pass_mask & bus.fail_mask), 32'd0);
        chk({tag, " masks cover"}, 32'(bus.pass_mask | bus.fail_mask), 32'hF);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset     = 1'b1;
        bus.start = 1'b1;
        cfg_all(10, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst bist_reset", 32'(bus.bist_reset), 32'hF);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst link_sel", 32'(bus.link_sel), 32'd0);
        chk("rst pass", 32'(bus.pass_mask), 32'd0);
        chk("rst fail", 32'(bus.fail_mask), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start under reset ignored", 32'(bus.busy), 32'd0);

        // All pass, with a start pulse mid-sequence that must be ignored.
        cfg_all(10, 1'b0);
        go();
        repeat (20) @(posedge clk);
        #1;
        chk("busy mid-seq", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("allpass");
        chk("allpass pass", 32'(bus.pass_mask), 32'hF);
        chk("allpass fail", 32'(bus.fail_mask), 32'h0);
        chk("allpass bist_reset", 32'(bus.bist_reset), 32'h0);
        chk("allpass lo0", 32'(lo_cnt[0]), 32'd11);
        chk("allpass hi0", 32'(hi_cnt[0]), 32'd2);
        chk("allpass lo3", 32'(lo_cnt[3]), 32'd11);

        // Retry success on link 2, started from DONE.
        cfg_all(10, 1'b0);
        fl[2][0] = 1'b1;
        go();
        chk("restart pass clr", 32'(bus.pass_mask), 32'h0);
        chk("restart fail clr", 32'(bus.fail_mask), 32'h0);
        chk("restart busy", 32'(bus.busy), 32'd1);
        chk("restart done", 32'(bus.done), 32'd0);
        chk("restart sel", 32'(bus.link_sel), 32'd0);
        chk("restart bist_reset", 32'(bus.bist_reset), 32'hF);
        wait_done("retry");
        chk("retry pass", 32'(bus.pass_mask), 32'hF);
        chk("retry fail", 32'(bus.fail_mask), 32'h0);
        chk("retry hi2", 32'(hi_cnt[2]), 32'd4);
        chk("retry lo2", 32'(lo_cnt[2]), 32'd22);

        // Hard fail on link 1, link 3 never ready.
        cfg_all(3, 1'b0);
        dly[1][0] = 5; dly[1][1] = 5; fl[1][0] = 1'b1; fl[1][1] = 1'b1;
        dly[3][0] = 1000; dly[3][1] = 1000;
        go();
        wait_done("hardfail");
        chk("hardfail pass", 32'(bus.pass_mask), 32'h5);
        chk("hardfail fail", 32'(bus.fail_mask), 32'hA);
        chk("hardfail bist_reset", 32'(bus.bist_reset), 32'hA);
        chk("hardfail lo1", 32'(lo_cnt[1]), 32'd12);
        chk("hardfail lo3", 32'(lo_cnt[3]), 32'd130);
        chk("hardfail hi3", 32'(hi_cnt[3]), 32'd4);

        // Ready on the last timeout cycle passes; one cycle later fails. Others toggle freely.
        cfg_all(4, 1'b0);
        dly[0][0] = 64;
        dly[1][0] = 65; dly[1][1] = 65;
        noise = 1'b1;
        go();
        wait_done("coincide");
        noise = 1'b0;
        chk("coincide pass", 32'(bus.pass_mask), 32'hD);
        chk("coincide fail", 32'(bus.fail_mask), 32'h2);
        chk("coincide lo0", 32'(lo_cnt[0]), 32'd65);
        chk("coincide lo1", 32'(lo_cnt[1]), 32'd130);

        // Async reset while link 2 is running.
        cfg_all(10, 1'b0);
        go();
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bus.busy && bus.link_sel == 2'd2 && !bus.bist_reset[2]) break;
        end
        chk("midrun reached", 32'(k < 500), 32'd1);
        chk("midrun pass pre", 32'(bus.pass_mask), 32'h3);
        #1 reset = 1'b1;
        #1;
        chk("midrun bist_reset", 32'(bus.bist_reset), 32'hF);
        chk("midrun busy", 32'(bus.busy), 32'd0);
        chk("midrun done", 32'(bus.done), 32'd0);
        chk("midrun sel", 32'(bus.link_sel), 32'd0);
        chk("midrun pass", 32'(bus.pass_mask), 32'h0);
        chk("midrun fail", 32'(bus.fail_mask), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        go();
        wait_done("rerun");
        chk("rerun pass", 32'(bus.pass_mask), 32'hF);
        chk("rerun lo0", 32'(lo_cnt[0]), 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
Top-level BIST controller for the router's inter-node links. It runs the per-link LFSR BIST transmitter/receiver pairs one at a time after power-up or on request, applies a timeout and bounded retry per link, and publishes per-link pass/fail masks. Passing links are left out of BIST reset so their receivers forward traffic. Failing or untested links stay in reset so the routing logic can mask them out.

Parameters:
NUM_LINKS, 5, number of link BIST pairs sequenced (>=1)
RESET_CYCLES, 2, cycles bist_reset is held high per attempt (>=1)
TIMEOUT_CYCLES, 2048, max RUN cycles per attempt before declaring failure
MAX_RETRIES, 1, extra attempts after a failed attempt (0 = single attempt)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; begins a full sequence when idle or done
link_ready  input  NUM_LINKS  per-link receiver ready (test finished or failed)
link_failed  input  NUM_LINKS  per-link receiver failed flag
bist_reset  output  NUM_LINKS  per-link reset to the tx/rx BIST pair
busy  output  1  sequence in progress
done  output  1  sequence complete; held until the next start
link_sel  output  LW  index of link under test, LW = max(1, $clog2(NUM_LINKS))
pass_mask  output  NUM_LINKS  links that passed
fail_mask  output  NUM_LINKS  links that failed or timed out

Behaviour:
- Reset (async): state IDLE; bist_reset all 1s; busy=0, done=0, link_sel=0, pass_mask=0, fail_mask=0; all counters 0.
- States: IDLE, LINK_RST, RUN, RECORD, DONE.
- IDLE/DONE + start=1: next cycle enters LINK_RST with link_sel=0, busy=1, done=0. pass_mask, fail_mask and retry count clear. bist_reset goes to all 1s.
- start is ignored while busy.
- LINK_RST: bist_reset[link_sel]=1 for exactly RESET_CYCLES cycles, then RUN. The timeout counter clears on entry to RUN.
- RUN: bist_reset[link_sel]=0. Each cycle:
  - link_ready[link_sel]=1 -> RECORD, result = ~link_failed[link_sel].
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 -> RECORD with result=fail.
  - Readiness wins if it coincides with the timeout.
  - Timeout counter width = $clog2(TIMEOUT_CYCLES+1).
- RECORD (1 cycle):
  - Pass: set pass_mask[link_sel]. The link stays out of reset.
  - Fail with retries < MAX_RETRIES: increment retries, return to LINK_RST on the same link.
  - Fail with retries exhausted: set fail_mask[link_sel], re-assert bist_reset[link_sel].
  - After a final result: if link_sel==NUM_LINKS-1 -> DONE; otherwise link_sel+1, retries=0, go to LINK_RST.
- DONE: busy=0, done=1. Masks and bist_reset are held: passing bits are 0, failing bits are 1.
- Invariants: pass_mask & fail_mask == 0 always. Once done=1, pass_mask | fail_mask == all 1s.
- Untested links keep bist_reset=1 throughout.
- Inputs from non-selected links are ignored.
- Reset mid-sequence: immediate return to the reset values above. No partial results are retained.
- start coinciding with reset: reset wins.

Decomposition:
- bist_pkg holds:
  - the bist_seq_state_t enum (IDLE, LINK_RST, RUN, RECORD, DONE);
  - the link index width function;
  - default parameter constants shared with the BIST transmitter/receiver (seed, test case count).
- One sub-module, bist_timer: loadable down-counter with clear and expire outputs. It is reused for the LINK_RST hold and the RUN timeout.

Test Plan:
(All with NUM_LINKS=4, RESET_CYCLES=2, TIMEOUT_CYCLES=64, MAX_RETRIES=1.)
- All pass: each link raises link_ready with link_failed=0 10 cycles into RUN -> done=1, pass_mask=4'b1111, fail_mask=0, bist_reset=0, busy low exactly at the DONE cycle.
- Retry success: link 2 fails its first attempt and passes its second -> bist_reset[2] pulses high 2 cycles twice, pass_mask=4'b1111, fail_mask=0.
- Hard fail plus timeout: link 1 fails both attempts, link 3 never raises ready -> link 3 spends 64 RUN cycles per attempt, fail_mask=4'b1010, pass_mask=4'b0101, bist_reset=4'b1010.
- Coincidence and isolation:
  - link_ready rises on the final timeout cycle -> result is taken from link_failed (pass).
  - A non-selected link toggling link_ready/link_failed has no effect.
- Start handling: start pulsed while busy is ignored. start pulsed in DONE -> masks clear and the sequence reruns from link 0.
- Async reset asserted mid-RUN on link 2 -> same cycle: all outputs at reset values, bist_reset=4'b1111. A later start runs the full sequence.
